// File: rtl/divergence_stack_pkg.sv
// ============================================================================
// Module  : divergence_stack_pkg
// Brief   : Shared encodings and entry layout for the SIMT reconvergence stack
// Revision: 1.0
// ============================================================================
`default_nettype none

package divergence_stack_pkg;

    localparam int unsigned DS_SP_PER_MP   = 8;
    localparam int unsigned DS_PC_WIDTH    = 32;
    localparam int unsigned DS_STACK_DEPTH = 8;

    // Branch evaluator outcome encoding (2'b11 is unused and never pushes)
    localparam logic [1:0] DIV_SPLIT = 2'b00;
    localparam logic [1:0] DIV_NONE  = 2'b01;
    localparam logic [1:0] DIV_ALL   = 2'b10;

    typedef struct packed {
        logic [DS_PC_WIDTH-1:0]  reconv_pc;
        logic [DS_SP_PER_MP-1:0] orig_mask;
        logic [DS_SP_PER_MP-1:0] nt_mask;
        logic [DS_PC_WIDTH-1:0]  nt_pc;
    } stack_entry_t;

endpackage

`default_nettype wire

// File: rtl/divergence_stack_mem.sv
// ============================================================================
// Module  : divergence_stack_mem
// Brief   : Entry register file with write, phase-set and top-read ports
// Revision: 1.0
// ============================================================================
`default_nettype none

module divergence_stack_mem
    import divergence_stack_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = DS_STACK_DEPTH,
    parameter int unsigned AW          = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  stack_entry_t  wr_entry,
    input  logic          phase_set,
    input  logic [AW-1:0] phase_idx,
    input  logic [AW-1:0] rd_idx,
    output stack_entry_t  rd_entry,
    output logic          rd_phase
);

    stack_entry_t           entries_q [STACK_DEPTH];
    stack_entry_t           entries_d [STACK_DEPTH];
    logic [STACK_DEPTH-1:0] phase_q;
    logic [STACK_DEPTH-1:0] phase_d;

    always_comb begin
        entries_d = entries_q;
        phase_d   = phase_q;
        // A freshly written entry always starts on its taken path
        if (wr_en) begin
            entries_d[wr_idx] = wr_entry;
            phase_d[wr_idx]   = 1'b0;
        end
        if (phase_set) begin
            phase_d[phase_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Payload needs no reset: an entry is only read once it has been written
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    assign rd_entry = entries_q[rd_idx];
    assign rd_phase = phase_q[rd_idx];

endmodule

`default_nettype wire

// File: rtl/divergence_stack.sv
// ============================================================================
// Module  : divergence_stack
// Brief   : Per-MP SIMT reconvergence stack driving fetch redirects
// Revision: 1.0
// ============================================================================
`default_nettype none

module divergence_stack
    import divergence_stack_pkg::*;
#(
    parameter int unsigned SP_PER_MP   = DS_SP_PER_MP,
    parameter int unsigned PC_WIDTH    = DS_PC_WIDTH,
    parameter int unsigned STACK_DEPTH = DS_STACK_DEPTH,
    localparam int unsigned DW         = $clog2(STACK_DEPTH + 1),
    localparam int unsigned AW         = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 br_valid,
    input  logic [1:0]           diverging,
    input  logic [SP_PER_MP-1:0] cur_mask,
    input  logic [SP_PER_MP-1:0] stack_mask,
    input  logic [PC_WIDTH-1:0]  not_taken_pc,
    input  logic [PC_WIDTH-1:0]  reconv_pc,
    input  logic                 pc_valid,
    input  logic [PC_WIDTH-1:0]  cur_pc,
    output logic                 restore_valid,
    output logic [PC_WIDTH-1:0]  restore_pc,
    output logic [SP_PER_MP-1:0] restore_mask,
    output logic [DW-1:0]        depth,
    output logic                 empty,
    output logic                 full,
    output logic                 overflow
);

    logic [DW-1:0]        depth_q, depth_d;
    logic                 empty_q, empty_d;
    logic                 full_q, full_d;
    logic                 overflow_q, overflow_d;
    logic                 restore_valid_q, restore_valid_d;
    logic [PC_WIDTH-1:0]  restore_pc_q, restore_pc_d;
    logic [SP_PER_MP-1:0] restore_mask_q, restore_mask_d;

    logic                 wr_en;
    logic                 phase_set;
    logic [AW-1:0]        top_idx;
    logic [AW-1:0]        wr_idx;
    stack_entry_t         wr_entry;
    stack_entry_t         top_entry;
    logic                 top_phase;
    logic                 match;
    logic                 push_req;

    assign top_idx  = AW'(depth_q - DW'(1));
    assign wr_idx   = AW'(depth_q);
    assign wr_entry = '{reconv_pc: reconv_pc, orig_mask: cur_mask,
                        nt_mask: stack_mask, nt_pc: not_taken_pc};

    divergence_stack_mem #(
        .STACK_DEPTH (STACK_DEPTH),
        .AW          (AW)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_entry  (wr_entry),
        .phase_set (phase_set),
        .phase_idx (top_idx),
        .rd_idx    (top_idx),
        .rd_entry  (top_entry),
        .rd_phase  (top_phase)
    );

    // Only the top entry can reconverge; a redirect squashes any branch in the same cycle
    assign match    = pc_valid && !empty_q && (cur_pc == top_entry.reconv_pc);
    assign push_req = br_valid && (diverging == DIV_SPLIT) && !match;

    always_comb begin
        depth_d         = depth_q;
        overflow_d      = overflow_q;
        restore_valid_d = 1'b0;
        restore_pc_d    = restore_pc_q;
        restore_mask_d  = restore_mask_q;
        wr_en           = 1'b0;
        phase_set       = 1'b0;

        if (match) begin
            restore_valid_d = 1'b1;
            if (!top_phase) begin
                restore_pc_d   = top_entry.nt_pc;
                restore_mask_d = top_entry.nt_mask;
                phase_set      = 1'b1;
            end else begin
                restore_pc_d   = top_entry.reconv_pc;
                restore_mask_d = top_entry.orig_mask;
                depth_d        = depth_q - DW'(1);
            end
        end else if (push_req) begin
            if (full_q) begin
                overflow_d = 1'b1;
            end else begin
                wr_en   = 1'b1;
                depth_d = depth_q + DW'(1);
            end
        end

        empty_d = (depth_d == '0);
        full_d  = (depth_d == DW'(STACK_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            depth_q         <= '0;
            empty_q         <= 1'b1;
            full_q          <= 1'b0;
            overflow_q      <= 1'b0;
            restore_valid_q <= 1'b0;
            restore_pc_q    <= '0;
            restore_mask_q  <= '0;
        end else begin
            depth_q         <= depth_d;
            empty_q         <= empty_d;
            full_q          <= full_d;
            overflow_q      <= overflow_d;
            restore_valid_q <= restore_valid_d;
            restore_pc_q    <= restore_pc_d;
            restore_mask_q  <= restore_mask_d;
        end
    end

    assign depth         = depth_q;
    assign empty         = empty_q;
    assign full          = full_q;
    assign overflow      = overflow_q;
    assign restore_valid = restore_valid_q;
    assign restore_pc    = restore_pc_q;
    assign restore_mask  = restore_mask_q;

endmodule

`default_nettype wire

// File: doc/divergence_stack.md
Name: divergence_stack

Overview:
- Per-MP SIMT reconvergence stack. It sits at the consuming end of the branch evaluator and takes the evaluator's stack_mask and diverging code.
- On a divergent branch it records the not-taken path and the reconvergence point.
- It redirects fetch (PC and active mask) to the not-taken path when the taken path reaches the reconvergence PC.
- It restores the pre-branch mask when the not-taken path arrives at the same PC.

Parameters:
- SP_PER_MP, 8, number of SPs per MP (mask width).
- PC_WIDTH, 32, instruction address width.
- STACK_DEPTH, 8, maximum nested divergence entries.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- br_valid  input  1  branch resolved this cycle
- diverging  input  2  from branch evaluator: 00 diverging, 01 all not taken, 10 all taken
- cur_mask  input  SP_PER_MP  active mask at the branch (pre-branch)
- stack_mask  input  SP_PER_MP  enabled threads that did not take the branch
- not_taken_pc  input  PC_WIDTH  fall-through PC of the branch
- reconv_pc  input  PC_WIDTH  reconvergence PC supplied with the branch
- pc_valid  input  1  cur_pc holds an instruction being issued
- cur_pc  input  PC_WIDTH  PC being issued
- restore_valid  output  1  one-cycle pulse: fetch must load restore_pc / restore_mask
- restore_pc  output  PC_WIDTH  redirect PC
- restore_mask  output  SP_PER_MP  redirect active mask
- depth  output  $clog2(STACK_DEPTH+1)  occupied entries
- empty  output  1  depth == 0
- full  output  1  depth == STACK_DEPTH
- overflow  output  1  sticky: push attempted while full

Behaviour:
- Entry fields: reconv_pc, orig_mask (cur_mask), nt_mask (stack_mask), nt_pc, phase (0 = taken path running, 1 = not-taken path running).
- Reset (rst_n low at a clk edge):
  - depth = 0; all phase bits = 0.
  - restore_valid, restore_pc, restore_mask, overflow = 0; empty = 1; full = 0.
  - Reset mid-operation discards all entries.
- Push condition: br_valid && diverging == 2'b00 && no match this cycle.
  - Writes the entry at index depth with phase = 0; depth increments.
  - diverging 01, 10 or 11 never pushes.
- Match condition: pc_valid && !empty && cur_pc == top.reconv_pc.
  - Top phase 0: restore_pc = top.nt_pc, restore_mask = top.nt_mask, top.phase <= 1; depth unchanged.
  - Top phase 1: restore_pc = top.reconv_pc, restore_mask = top.orig_mask; pop (depth decrements).
  - Only the top entry is compared.
- Latency: restore_* are registered and valid the cycle after the matching cur_pc. restore_valid is high exactly one cycle; restore_pc and restore_mask hold their value afterwards.
- Simultaneous match and push: the match wins; the push is dropped with no flag. The branch is squashed by the redirect.
- Full: a push when depth == STACK_DEPTH writes nothing, depth stays, and overflow sets and stays set until reset.
- A match cannot occur when empty. pc_valid low means no compare.
- full, empty and depth are registered from the pointer with no extra latency beyond the pointer update.
- Nested divergence: inner entries push above outer ones. The LIFO ordering guarantees inner reconvergence resolves first.

Decomposition:
- Shared package: the diverging encoding constants (DIV_SPLIT = 2'b00, DIV_NONE = 2'b01, DIV_ALL = 2'b10) and a packed stack_entry_t struct parameterised through localparams.
- One sub-module is natural: divergence_stack_mem, a STACK_DEPTH x entry register file with a write port, a phase-set port and a top-read port.
- Pointer, match and restore logic stay in divergence_stack.

Test Plan:
- Reset then idle: no br_valid → empty = 1, depth = 0, restore_valid = 0 for 20 cycles.
- Push then first reconvergence:
  - Stimulus: br_valid, diverging = 00, cur_mask = 8'hFF, stack_mask = 8'h0F, not_taken_pc = 0x104, reconv_pc = 0x200.
  - Response: depth = 1.
  - Then cur_pc = 0x200 with pc_valid → next cycle restore_valid = 1, restore_pc = 0x104, restore_mask = 8'h0F, depth = 1.
- Second reconvergence: continuing, cur_pc = 0x200 again → restore_pc = 0x200, restore_mask = 8'hFF, depth = 0, empty = 1.
- Non-divergent branches: diverging = 01, then 10 → no push, depth stays 0.
- Nested divergence:
  - Stimulus: outer push (reconv 0x300, mask FF/F0), then inner push (reconv 0x280, mask F0/30).
  - Response: cur_pc = 0x280 twice gives 0x30, then 0xF0; then 0x300 twice gives the outer nt_mask 8'hF0, then 8'hFF; final depth = 0.
- Overflow: 9 divergent pushes with STACK_DEPTH = 8 → full = 1, depth = 8, overflow = 1.
- Collision: a match coincides with a divergent br_valid → redirect occurs, depth unchanged by the push.
- Reset while depth = 3: asserting rst_n = 0 for one clk → depth = 0 and overflow = 0.
